// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, PC increment and FSM state type for the fetch controller
package fetch_pkg;

   localparam int XLEN = 64;
   localparam int ILEN = 32;
   localparam logic [XLEN-1:0] PC_INC = 64'd4;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      HALT
   } fetch_state_e;

   // Fetch addresses are always word aligned; the low two bits of a target are ignored.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return addr & ~(PC_INC - 64'd1);
   endfunction

endpackage

// File: rtl/se_four_adder.sv
// rtl/se_four_adder.sv - PC + 4 incrementer with carry-out
module se_four_adder
   import fetch_pkg::*;
(
   input  logic [XLEN-1:0] pco_i,
   output logic [XLEN-1:0] nextAddr_o,
   output logic            c_o
);

   assign {c_o, nextAddr_o} = {1'b0, pco_i} + {1'b0, PC_INC};

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - single-outstanding instruction fetch FSM with redirect; PC_FETCH_PERF_EN adds a handshake counter
module pc_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = 64'h0
)
(
   input  logic            clk_i,
   input  logic            rst_ni,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [ILEN-1:0] imem_rdata_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [ILEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_addr_i,
   output logic            pc_wrap_o
`ifdef PC_FETCH_PERF_EN
   ,
   output logic [31:0]     perf_fetch_cnt_o
`endif
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_next;
   logic            pc_carry;
   logic            drop_q, drop_d;
   logic            wrap_q, wrap_d;
   logic [ILEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] instr_pc_q, instr_pc_d;

   se_four_adder u_pc_adder (
      .pco_i      (pc_q),
      .nextAddr_o (pc_next),
      .c_o        (pc_carry)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         pc_q       <= RESET_VECTOR;
         drop_q     <= 1'b0;
         wrap_q     <= 1'b0;
         instr_q    <= '0;
         instr_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drop_q     <= drop_d;
         wrap_q     <= wrap_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drop_d     = drop_q;
      wrap_d     = wrap_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      imem_req_o = 1'b0;

      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            imem_req_o = 1'b1;
            if (imem_gnt_i) state_d = WAIT;
         end
         WAIT: begin
            if (imem_rvalid_i) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  instr_d    = imem_rdata_i;
                  instr_pc_d = pc_q;
                  state_d    = HOLD;
               end
            end
         end
         HOLD: begin
            if (instr_ready_i) begin
               pc_d = pc_next;
               if (pc_carry) begin
                  wrap_d  = 1'b1;
                  state_d = HALT;
               end else begin
                  state_d = REQ;
               end
            end
         end
         HALT: state_d = HALT;
         default: state_d = IDLE;
      endcase

      // Redirect wins over everything above; a response already in flight is marked for discard.
      if (redirect_valid_i) begin
         pc_d       = align_pc(redirect_addr_i);
         wrap_d     = 1'b0;
         instr_d    = instr_q;
         instr_pc_d = instr_pc_q;
         case (state_q)
            REQ: begin
               drop_d  = imem_gnt_i;
               state_d = imem_gnt_i ? WAIT : REQ;
            end
            WAIT: begin
               drop_d  = !imem_rvalid_i;
               state_d = imem_rvalid_i ? REQ : WAIT;
            end
            default: begin
               drop_d  = 1'b0;
               state_d = REQ;
            end
         endcase
      end
   end

   assign imem_addr_o   = pc_q;
   assign instr_valid_o = (state_q == HOLD);
   assign instr_o       = instr_q;
   assign instr_pc_o    = instr_pc_q;
   assign pc_wrap_o     = wrap_q;

`ifdef PC_FETCH_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_q <= '0;
      end else if (instr_valid_o && instr_ready_i && (perf_q != 32'hFFFF_FFFF)) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign perf_fetch_cnt_o = perf_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - scoreboard bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        imem_req_o;
   logic [63:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic        instr_valid_o;
   logic        instr_ready_i = 1'b0;
   logic [31:0] instr_o;
   logic [63:0] instr_pc_o;
   logic        redirect_valid_i = 1'b0;
   logic [63:0] redirect_addr_i = '0;
   logic        pc_wrap_o;
`ifdef PC_FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   logic [63:0] exp_addr_q[$];
   logic [63:0] exp_pc_q[$];
   logic [31:0] exp_ins_q[$];

   pc_fetch_ctrl #(.RESET_VECTOR(64'h0)) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .imem_req_o       (imem_req_o),
      .imem_addr_o      (imem_addr_o),
      .imem_gnt_i       (imem_gnt_i),
      .imem_rvalid_i    (imem_rvalid_i),
      .imem_rdata_i     (imem_rdata_i),
      .instr_valid_o    (instr_valid_o),
      .instr_ready_i    (instr_ready_i),
      .instr_o          (instr_o),
      .instr_pc_o       (instr_pc_o),
      .redirect_valid_i (redirect_valid_i),
      .redirect_addr_i  (redirect_addr_i),
      .pc_wrap_o        (pc_wrap_o)
`ifdef PC_FETCH_PERF_EN
      ,
      .perf_fetch_cnt_o (perf_fetch_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] mdata(input logic [63:0] a);
      return a[31:0] ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_req(output bit ok);
      for (int n = 0; n < 20 && !imem_req_o; n++) step();
      ok = imem_req_o;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL wait_req: imem_req_o got 0 after 20 cycles, required 1");
      end
   endtask

   task automatic fetch(input logic [63:0] pc, input int gd, input int rd, input int hd);
      bit ok;
      wait_req(ok);
      if (!ok) return;
      exp_addr_q.push_back(pc);
      exp_pc_q.push_back(pc);
      exp_ins_q.push_back(mdata(pc));
      repeat (gd) step();
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i = 1'b0;
      repeat (rd) step();
      imem_rdata_i  = mdata(pc);
      imem_rvalid_i = 1'b1;
      step();
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'hDEAD_BEEF;
      chk("hold_valid", 64'(instr_valid_o), 64'd1);
      for (int i = 0; i < hd; i++) begin
         chk("hold_no_req", 64'(imem_req_o), 64'd0);
         chk("hold_instr", 64'(instr_o), 64'(mdata(pc)));
         chk("hold_pc", instr_pc_o, pc);
         step();
         chk("hold_valid_stall", 64'(instr_valid_o), 64'd1);
      end
      instr_ready_i = 1'b1;
      step();
      instr_ready_i = 1'b0;
   endtask

   task automatic pulse_redirect(input logic [63:0] a);
      redirect_valid_i = 1'b1;
      redirect_addr_i  = a;
      step();
      redirect_valid_i = 1'b0;
   endtask

   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (imem_req_o && imem_gnt_i) begin
            if (exp_addr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_grant: addr %h granted, none required", imem_addr_o);
            end else begin
               chk("grant_addr", imem_addr_o, exp_addr_q.pop_front());
            end
         end
         if (instr_valid_o && instr_ready_i) begin
            if (exp_pc_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_instr: pc %h delivered, none required", instr_pc_o);
            end else begin
               chk("instr_pc", instr_pc_o, exp_pc_q.pop_front());
               chk("instr_data", 64'(instr_o), 64'(exp_ins_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_req", 64'(imem_req_o), 64'd0);
      chk("rst_addr", imem_addr_o, 64'h0);
      chk("rst_valid", 64'(instr_valid_o), 64'd0);
      chk("rst_instr", 64'(instr_o), 64'd0);
      chk("rst_instr_pc", instr_pc_o, 64'h0);
      chk("rst_wrap", 64'(pc_wrap_o), 64'd0);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // sequential fetches, grant and data one cycle late
      for (int i = 0; i < 3; i++) fetch(64'(4 * i), 1, 1, 0);
      // decode stall
      fetch(64'hC, 0, 0, 5);

      // redirect while waiting for data; late word must be dropped
      wait_req(ok);
      exp_addr_q.push_back(64'h10);
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i = 1'b0;
      pulse_redirect(64'h1003);
      chk("drop_valid_a", 64'(instr_valid_o), 64'd0);
      step();
      chk("drop_valid_b", 64'(instr_valid_o), 64'd0);
      imem_rdata_i  = mdata(64'h10);
      imem_rvalid_i = 1'b1;
      step();
      imem_rvalid_i = 1'b0;
      chk("drop_valid_c", 64'(instr_valid_o), 64'd0);
      chk("drop_req", 64'(imem_req_o), 64'd1);
      chk("drop_addr", imem_addr_o, 64'h1000);
      fetch(64'h1000, 0, 0, 0);

      // redirect together with grant
      wait_req(ok);
      exp_addr_q.push_back(64'h1004);
      imem_gnt_i = 1'b1;
      pulse_redirect(64'h3000);
      imem_gnt_i = 1'b0;
      chk("rg_wait_no_req", 64'(imem_req_o), 64'd0);
      imem_rdata_i  = mdata(64'h1004);
      imem_rvalid_i = 1'b1;
      step();
      imem_rvalid_i = 1'b0;
      chk("rg_valid", 64'(instr_valid_o), 64'd0);
      chk("rg_addr", imem_addr_o, 64'h3000);
      fetch(64'h3000, 0, 0, 0);

      // redirect together with returning data
      wait_req(ok);
      exp_addr_q.push_back(64'h3004);
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i = 1'b0;
      imem_rdata_i  = mdata(64'h3004);
      imem_rvalid_i = 1'b1;
      pulse_redirect(64'h4002);
      imem_rvalid_i = 1'b0;
      chk("rv_valid", 64'(instr_valid_o), 64'd0);
      chk("rv_req", 64'(imem_req_o), 64'd1);
      chk("rv_addr", imem_addr_o, 64'h4000);

      // redirect in HOLD together with decode acceptance
      exp_addr_q.push_back(64'h4000);
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i = 1'b0;
      imem_rdata_i  = mdata(64'h4000);
      imem_rvalid_i = 1'b1;
      step();
      imem_rvalid_i = 1'b0;
      chk("rh_valid_before", 64'(instr_valid_o), 64'd1);
      exp_pc_q.push_back(64'h4000);
      exp_ins_q.push_back(mdata(64'h4000));
      instr_ready_i = 1'b1;
      pulse_redirect(64'h5000);
      instr_ready_i = 1'b0;
      chk("rh_valid_after", 64'(instr_valid_o), 64'd0);
      chk("rh_addr", imem_addr_o, 64'h5000);
      fetch(64'h5000, 0, 0, 0);

      // PC wrap into HALT, then leave by redirect
      pulse_redirect(64'hFFFF_FFFF_FFFF_FFFF);
      chk("wrap_target_addr", imem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
      fetch(64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         chk("halt_wrap", 64'(pc_wrap_o), 64'd1);
         chk("halt_req", 64'(imem_req_o), 64'd0);
         chk("halt_addr", imem_addr_o, 64'h0);
         step();
      end
      pulse_redirect(64'h200);
      chk("unhalt_wrap", 64'(pc_wrap_o), 64'd0);
      chk("unhalt_req", 64'(imem_req_o), 64'd1);
      chk("unhalt_addr", imem_addr_o, 64'h200);
      fetch(64'h200, 0, 0, 0);
`ifdef PC_FETCH_PERF_EN
      chk("perf_count", 64'(perf_fetch_cnt_o), 64'd10);
`endif

      // asynchronous reset while waiting for data
      wait_req(ok);
      exp_addr_q.push_back(64'h204);
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i = 1'b0;
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_req", 64'(imem_req_o), 64'd0);
      chk("arst_addr", imem_addr_o, 64'h0);
      chk("arst_valid", 64'(instr_valid_o), 64'd0);
      chk("arst_instr", 64'(instr_o), 64'd0);
      chk("arst_instr_pc", instr_pc_o, 64'h0);
      chk("arst_wrap", 64'(pc_wrap_o), 64'd0);
      step();
      step();
      imem_rdata_i  = mdata(64'h204);
      imem_rvalid_i = 1'b1;
      rst_ni = 1'b1;
      step();
      step();
      imem_rvalid_i = 1'b0;
      chk("late_rvalid_valid", 64'(instr_valid_o), 64'd0);
      chk("late_rvalid_addr", imem_addr_o, 64'h0);
      fetch(64'h0, 0, 0, 0);
      fetch(64'h4, 0, 0, 0);

      // redirect on the first cycle out of reset
      rst_ni = 1'b0;
      step();
      step();
      rst_ni = 1'b1;
      pulse_redirect(64'h800);
      chk("idle_redir_req", 64'(imem_req_o), 64'd1);
      chk("idle_redir_addr", imem_addr_o, 64'h800);
      fetch(64'h800, 0, 0, 0);
`ifdef PC_FETCH_PERF_EN
      chk("perf_after_reset", 64'(perf_fetch_cnt_o), 64'd1);
`endif

      step();
      chk("sb_addr_empty", 64'(exp_addr_q.size()), 64'd0);
      chk("sb_instr_empty", 64'(exp_pc_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
